// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the in-order MEM/WB
//   writeback stream and an out-of-band long-latency unit (divider / multi-
//   cycle ALU). Pipeline writes win; long-latency results wait in a small FIFO
//   and drain in idle writeback cycles. A younger pipeline write to the same
//   register kills any queued result for that register.
//
//   Optional feature macro: WB_ARB_STARVE_EN
//     defined   : a wait counter on the FIFO head raises stall_req for one
//                 cycle so the head can be drained while the pipeline freezes.
//     undefined : stall_req is tied low; the FIFO drains only in idle cycles.
//
// Parameters
//   DEPTH    : FIFO entries (power of two, >= 2)
//   MAX_WAIT : cycles the FIFO head may wait before a forced drain (>= 1)
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   wb_wd, wb_wreg, wb_wdata      : pipeline writeback request
//   lu_valid, lu_wd, lu_wdata     : long-latency result, accepted when lu_ready
//   lu_ready                      : FIFO can accept a result
//   rf_we, rf_waddr, rf_wdata     : registered regfile write port
//   stall_req                     : registered one-cycle pipeline freeze request
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wb_wd,
  input  logic        wb_wreg,
  input  logic [31:0] wb_wdata,
  input  logic        lu_valid,
  input  logic [4:0]  lu_wd,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_port_arbiter: DEPTH must be a power of two >= 2");
  end
  if (MAX_WAIT < 1) begin : g_bad_wait
    $error("wb_port_arbiter: MAX_WAIT must be >= 1");
  end

  logic [DEPTH-1:0] q_vld;
  logic [4:0]       q_wd   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic empty;
  logic full;
  logic stall_q;
  logic pipe_win;
  logic pop;
  logic push_keep;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  // Held low while rst is asserted so no handshake can complete during reset.
  assign lu_ready = !rst && !full;

  // During a stall the frozen pipeline write is deferred and the head drains.
  assign pipe_win = !stall_q && wb_wreg && (wb_wd != 5'd0);
  assign pop      = !empty && !pipe_win;

  // Results for r0, or for the register a younger pipeline write is updating
  // this very cycle, complete the handshake but are never stored.
  assign push_keep = lu_valid && lu_ready && (lu_wd != 5'd0) &&
                     !(pipe_win && (lu_wd == wb_wd));

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      q_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_wd[i]   <= 5'd0;
        q_data[i] <= 32'h0;
      end
    end else begin
      // Superseded entries keep their slot; they pop as a no-op write.
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_win && (q_wd[i] == wb_wd)) begin
          q_vld[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_vld[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (push_keep) begin
        q_vld[tail]  <= 1'b1;
        q_wd[tail]   <= lu_wd;
        q_data[tail] <= lu_wdata;
        tail         <= tail + PW'(1);
      end
      count <= count + CW'(push_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'h0;
    end else if (pipe_win) begin
      rf_we    <= 1'b1;
      rf_waddr <= wb_wd;
      rf_wdata <= wb_wdata;
    end else if (pop && q_vld[head]) begin
      rf_we    <= 1'b1;
      rf_waddr <= q_wd[head];
      rf_wdata <= q_data[head];
    end else begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'h0;
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (empty || pop) begin
        wait_cnt <= '0;
      end else if (q_vld[head] && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
      // A stall cycle always pops, so this also blocks back-to-back stalls;
      // no freeze is requested when the head is already draining.
      stall_q <= (wait_cnt == WAIT_MAX) && wb_wreg && !pop;
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic [4:0]  lu_wd;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .lu_valid  (lu_valid),
    .lu_wd     (lu_wd),
    .lu_wdata  (lu_wdata),
    .lu_ready  (lu_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] wd, input logic [31:0] d);
    wb_wreg  = we;
    wb_wd    = wd;
    wb_wdata = d;
  endtask

  task automatic drive_lu(input logic v, input logic [4:0] wd, input logic [31:0] d);
    lu_valid = v;
    lu_wd    = wd;
    lu_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_wb(1'b1, 5'd3, 32'hAAAA_0003);
    drive_lu(1'b1, 5'd5, 32'h5555_0005);
    tick();
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== 38'h0) begin
      errors++;
      $display("FAIL reset_rf: got we=%b addr=%0d data=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b want 0", stall_req);
    end
    checks++;
    if (lu_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_lu_ready: got %b want 0", lu_ready);
    end
    rst = 1'b0;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_lu(1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_lu_ready: got %b want 1", lu_ready);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== 38'h0) begin
      errors++;
      $display("FAIL post_reset_idle: got we=%b addr=%0d data=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_lu_single();
    drive_lu(1'b1, 5'd5, 32'hDEAD_BEEF);
    checks++;
    if (lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b want 1", lu_ready);
    end
    tick();
    drive_lu(1'b0, 5'd0, 32'h0);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got we=%b want 0", rf_we);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL single_write: got we=%b addr=%0d data=%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got we=%b want 0", rf_we);
    end
  endtask

  task automatic test_priority_full();
    logic [37:0] exp_rf [6];
    logic        exp_rdy [6];
    exp_rf[0] = {1'b1, 5'd3, 32'h0000_0100};
    exp_rf[1] = {1'b1, 5'd3, 32'h0000_0101};
    exp_rf[2] = {1'b1, 5'd3, 32'h0000_0102};
    exp_rf[3] = {1'b1, 5'd7, 32'h7777_0007};
    exp_rf[4] = {1'b1, 5'd8, 32'h8888_0008};
    exp_rf[5] = {1'b1, 5'd6, 32'h6666_0006};
    exp_rdy   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin drive_wb(1'b1, 5'd3, 32'h100); drive_lu(1'b1, 5'd7, 32'h7777_0007); end
        1: begin drive_wb(1'b1, 5'd3, 32'h101); drive_lu(1'b1, 5'd8, 32'h8888_0008); end
        2: begin drive_wb(1'b1, 5'd3, 32'h102); drive_lu(1'b1, 5'd6, 32'h6666_0006); end
        3: begin drive_wb(1'b0, 5'd0, 32'h0);   drive_lu(1'b1, 5'd6, 32'h6666_0006); end
        4: begin drive_wb(1'b0, 5'd0, 32'h0);   drive_lu(1'b1, 5'd6, 32'h6666_0006); end
        default: begin drive_wb(1'b0, 5'd0, 32'h0); drive_lu(1'b0, 5'd0, 32'h0); end
      endcase
      #1;
      checks++;
      if (lu_ready !== exp_rdy[c]) begin
        errors++;
        $display("FAIL prio_ready[%0d]: got %b want %b", c, lu_ready, exp_rdy[c]);
      end
      tick();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== exp_rf[c]) begin
        errors++;
        $display("FAIL prio_rf[%0d]: got %b/%0d/%h want %b/%0d/%h", c, rf_we, rf_waddr, rf_wdata,
                 exp_rf[c][37], exp_rf[c][36:32], exp_rf[c][31:0]);
      end
    end
    drive_lu(1'b0, 5'd0, 32'h0);
    tick();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL prio_drained: got we=%b want 0", rf_we);
    end
  endtask

  task automatic test_starvation();
    logic [31:0] d;
    logic        stall_seen;
    logic        exp_stall;
    logic [37:0] exp;
    d = 32'h200;
    for (int c = 0; c < 10; c++) begin
      drive_wb(1'b1, 5'd3, d);
      drive_lu(c == 0, 5'd9, 32'h9999_0009);
`ifdef WB_ARB_STARVE_EN
      exp_stall = (c == 6);
`else
      exp_stall = 1'b0;
`endif
      #1;
      checks++;
      if (stall_req !== exp_stall) begin
        errors++;
        $display("FAIL starve_stall[%0d]: got %b want %b", c, stall_req, exp_stall);
      end
      stall_seen = stall_req;
      tick();
      exp = exp_stall ? {1'b1, 5'd9, 32'h9999_0009} : {1'b1, 5'd3, d};
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== exp) begin
        errors++;
        $display("FAIL starve_rf[%0d]: got %b/%0d/%h want %b/%0d/%h", c, rf_we, rf_waddr, rf_wdata,
                 exp[37], exp[36:32], exp[31:0]);
      end
      if (!stall_seen) d = d + 32'h1;
    end
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_lu(1'b0, 5'd0, 32'h0);
    tick();
`ifdef WB_ARB_STARVE_EN
    exp = 38'h0;
`else
    exp = {1'b1, 5'd9, 32'h9999_0009};
`endif
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== exp) begin
      errors++;
      $display("FAIL starve_idle_drain: got %b/%0d/%h want %b/%0d/%h", rf_we, rf_waddr, rf_wdata,
               exp[37], exp[36:32], exp[31:0]);
    end
    tick();
  endtask

  task automatic test_supersede();
    drive_wb(1'b1, 5'd3, 32'h300);
    drive_lu(1'b1, 5'd4, 32'h4444_0004);
    tick();
    drive_wb(1'b1, 5'd4, 32'h1);
    drive_lu(1'b1, 5'd4, 32'h5555_0055);
    #1;
    checks++;
    if (lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL sup_ready: got %b want 1", lu_ready);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h1}) begin
      errors++;
      $display("FAIL sup_pipe: got %b/%0d/%h want 1/4/00000001", rf_we, rf_waddr, rf_wdata);
    end
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_lu(1'b0, 5'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (rf_we !== 1'b0) begin
        errors++;
        $display("FAIL sup_killed[%0d]: got we=%b addr=%0d data=%h want we=0", c, rf_we, rf_waddr, rf_wdata);
      end
    end
  endtask

  task automatic test_r0_push();
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_lu(1'b1, 5'd0, 32'h0000_1234);
    #1;
    checks++;
    if (lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL r0_ready: got %b want 1", lu_ready);
    end
    tick();
    drive_lu(1'b0, 5'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (rf_we !== 1'b0) begin
        errors++;
        $display("FAIL r0_no_write[%0d]: got we=%b addr=%0d want we=0", c, rf_we, rf_waddr);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_wb(1'b1, 5'd3, 32'h400);
    drive_lu(1'b1, 5'd5, 32'h5555_0505);
    tick();
    drive_lu(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, stall_req, lu_ready} !== 40'h0) begin
      errors++;
      $display("FAIL mid_reset: got we=%b addr=%0d data=%h stall=%b rdy=%b want all 0",
               rf_we, rf_waddr, rf_wdata, stall_req, lu_ready);
    end
    rst = 1'b0;
    drive_wb(1'b0, 5'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({rf_we, lu_ready} !== 2'b01) begin
        errors++;
        $display("FAIL mid_flushed[%0d]: got we=%b addr=%0d rdy=%b want we=0 rdy=1", c, rf_we, rf_waddr, lu_ready);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_lu(1'b0, 5'd0, 32'h0);
    test_reset();
    test_lu_single();
    test_priority_full();
    test_starvation();
    test_supersede();
    test_r0_push();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
